// File: rtl/vram_brush_painter.sv
// VRAM write-side controller: background fill on reset/request, then round-robin
// touch arbitration painting a clipped square brush per accepted touch.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | one background write per cycle, addresses ascending from 0
// ST_IDLE  | no writes; scan touch channels from rr pointer, latch first in-range
// ST_PAINT | (2R+1)^2 cycles, one brush pixel per cycle, off-screen pixels masked
module vram_brush_painter #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int COLOR_W        = 16,
    parameter int N_TOUCH        = 2,
    parameter int BRUSH_R        = 1,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = COLOR_W'(16'h000F),
    localparam int X_W    = $clog2(DISPLAY_WIDTH),
    localparam int Y_W    = $clog2(DISPLAY_HEIGHT),
    localparam int ADDR_W = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       clear_req,
    input  logic [N_TOUCH-1:0]         touch_valid,
    input  logic [N_TOUCH*X_W-1:0]     touch_x,
    input  logic [N_TOUCH*Y_W-1:0]     touch_y,
    input  logic [N_TOUCH*COLOR_W-1:0] pen_color,
    output logic                       vram_wr_ena,
    output logic [ADDR_W-1:0]          vram_wr_addr,
    output logic [COLOR_W-1:0]         vram_wr_data,
    output logic                       busy
);

    localparam int S_W  = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam int B    = 2 * BRUSH_R + 1;
    localparam int PC_W = (B * B > 1) ? $clog2(B * B) : 1;
    localparam int RR_W = (N_TOUCH > 1) ? $clog2(N_TOUCH) : 1;

    localparam logic signed [S_W-1:0] R_S   = S_W'(BRUSH_R);
    localparam logic signed [S_W-1:0] ONE_S = S_W'(1);
    localparam logic signed [S_W-1:0] W_S   = S_W'(DISPLAY_WIDTH);
    localparam logic signed [S_W-1:0] H_S   = S_W'(DISPLAY_HEIGHT);
    localparam logic [X_W:0]          W_X   = (X_W + 1)'(DISPLAY_WIDTH);
    localparam logic [Y_W:0]          H_Y   = (Y_W + 1)'(DISPLAY_HEIGHT);
    localparam logic [ADDR_W-1:0]     W_A   = ADDR_W'(DISPLAY_WIDTH);
    localparam logic [ADDR_W-1:0]     LAST_A  = ADDR_W'(DISPLAY_WIDTH * DISPLAY_HEIGHT - 1);
    localparam logic [PC_W-1:0]       PC_LOAD = PC_W'(B * B - 1);
    localparam logic [RR_W-1:0]       RR_LAST = RR_W'(N_TOUCH - 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_PAINT} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_W-1:0]      clr_cnt, clr_cnt_nxt;
    logic [RR_W-1:0]        rr, rr_nxt;
    logic [X_W-1:0]         cx, cx_nxt;
    logic [Y_W-1:0]         cy, cy_nxt;
    logic [COLOR_W-1:0]     color, color_nxt;
    logic signed [S_W-1:0]  dx, dx_nxt;
    logic signed [S_W-1:0]  dy, dy_nxt;
    logic [PC_W-1:0]        pc, pc_nxt;
    logic                   ena_nxt;
    logic [ADDR_W-1:0]      addr_nxt;
    logic [COLOR_W-1:0]     data_nxt;
    logic                   busy_nxt;

    logic [N_TOUCH-1:0]     ok;
    logic                   hit;
    logic [RR_W-1:0]        pick;
    int                     cand;
    logic [X_W-1:0]         sel_x;
    logic [Y_W-1:0]         sel_y;
    logic [COLOR_W-1:0]     sel_c;

    logic signed [S_W-1:0]  pix_x;
    logic signed [S_W-1:0]  pix_y;
    logic                   pix_in;
    logic [ADDR_W-1:0]      pix_addr;

    // A channel is eligible only when its coordinate lies on the display.
    always_comb begin
        ok = '0;
        for (int i = 0; i < N_TOUCH; i++) begin
            ok[i] = touch_valid[i]
                    && ({1'b0, touch_x[i*X_W +: X_W]} < W_X)
                    && ({1'b0, touch_y[i*Y_W +: Y_W]} < H_Y);
        end
    end

    always_comb begin
        hit  = 1'b0;
        pick = '0;
        cand = 0;
        for (int k = 0; k < N_TOUCH; k++) begin
            cand = int'(rr) + k;
            if (cand >= N_TOUCH) cand = cand - N_TOUCH;
            if (!hit && ok[RR_W'(cand)]) begin
                hit  = 1'b1;
                pick = RR_W'(cand);
            end
        end
    end

    assign sel_x = touch_x[int'(pick)*X_W +: X_W];
    assign sel_y = touch_y[int'(pick)*Y_W +: Y_W];
    assign sel_c = pen_color[int'(pick)*COLOR_W +: COLOR_W];

    // Signed offsets keep negative coordinates distinct, so clipping never wraps rows.
    assign pix_x    = $signed(S_W'(cx)) + dx;
    assign pix_y    = $signed(S_W'(cy)) + dy;
    assign pix_in   = !pix_x[S_W-1] && (pix_x < W_S) && !pix_y[S_W-1] && (pix_y < H_S);
    assign pix_addr = ADDR_W'($unsigned(pix_y)) * W_A + ADDR_W'($unsigned(pix_x));

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        rr_nxt      = rr;
        cx_nxt      = cx;
        cy_nxt      = cy;
        color_nxt   = color;
        dx_nxt      = dx;
        dy_nxt      = dy;
        pc_nxt      = pc;
        ena_nxt     = 1'b0;
        addr_nxt    = vram_wr_addr;
        data_nxt    = vram_wr_data;

        case (state)
            ST_CLEAR: begin
                ena_nxt  = 1'b1;
                addr_nxt = clr_cnt;
                data_nxt = CLEAR_COLOR;
                if (clr_cnt == LAST_A) begin
                    state_nxt   = ST_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (hit) begin
                    state_nxt = ST_PAINT;
                    cx_nxt    = sel_x;
                    cy_nxt    = sel_y;
                    color_nxt = sel_c;
                    dx_nxt    = -R_S;
                    dy_nxt    = -R_S;
                    pc_nxt    = PC_LOAD;
                    rr_nxt    = (pick == RR_LAST) ? '0 : pick + 1'b1;
                end
            end
            ST_PAINT: begin
                ena_nxt  = pix_in;
                addr_nxt = pix_addr;
                data_nxt = color;
                if (pc == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    pc_nxt = pc - 1'b1;
                end
                if (dx == R_S) begin
                    dx_nxt = -R_S;
                    dy_nxt = dy + ONE_S;
                end else begin
                    dx_nxt = dx + ONE_S;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase

        // Clear wins over everything, including a touch latched this same cycle.
        if (clear_req) begin
            state_nxt   = ST_CLEAR;
            clr_cnt_nxt = '0;
            ena_nxt     = 1'b0;
            rr_nxt      = rr;
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= ST_CLEAR;
            clr_cnt      <= '0;
            rr           <= '0;
            cx           <= '0;
            cy           <= '0;
            color        <= '0;
            dx           <= '0;
            dy           <= '0;
            pc           <= '0;
            vram_wr_ena  <= 1'b0;
            vram_wr_addr <= '0;
            vram_wr_data <= '0;
            busy         <= 1'b1;
        end else begin
            state        <= state_nxt;
            clr_cnt      <= clr_cnt_nxt;
            rr           <= rr_nxt;
            cx           <= cx_nxt;
            cy           <= cy_nxt;
            color        <= color_nxt;
            dx           <= dx_nxt;
            dy           <= dy_nxt;
            pc           <= pc_nxt;
            vram_wr_ena  <= ena_nxt;
            vram_wr_addr <= addr_nxt;
            vram_wr_data <= data_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_vram_brush_painter.sv
// Bench for vram_brush_painter on an 8x6 display: directed and random strokes
// checked cycle by cycle against a brush/clear model and a shadow image.
module tb_vram_brush_painter;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = 2;
    localparam int XW = 3;
    localparam int YW = 3;
    localparam int AW = 6;
    localparam int CW = 16;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic clear_req = 1'b0;
    logic [N-1:0]    touch_valid = '0;
    logic [N*XW-1:0] touch_x = '0;
    logic [N*YW-1:0] touch_y = '0;
    logic [N*CW-1:0] pen_color = '0;
    logic            wr_ena;
    logic [AW-1:0]   wr_addr;
    logic [CW-1:0]   wr_data;
    logic            busy;

    logic [N-1:0]    t0_valid = '0;
    logic [N*XW-1:0] t0_x = '0;
    logic [N*YW-1:0] t0_y = '0;
    logic [N*CW-1:0] t0_pen = '0;
    logic            r0_ena;
    logic [AW-1:0]   r0_addr;
    logic [CW-1:0]   r0_data;
    logic            r0_busy;

    vram_brush_painter #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .COLOR_W(CW),
                         .N_TOUCH(N), .BRUSH_R(1)) dut (
        .clk(clk), .rstb(rstb), .clear_req(clear_req),
        .touch_valid(touch_valid), .touch_x(touch_x), .touch_y(touch_y),
        .pen_color(pen_color), .vram_wr_ena(wr_ena), .vram_wr_addr(wr_addr),
        .vram_wr_data(wr_data), .busy(busy));

    vram_brush_painter #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .COLOR_W(CW),
                         .N_TOUCH(N), .BRUSH_R(0)) dut_r0 (
        .clk(clk), .rstb(rstb), .clear_req(1'b0),
        .touch_valid(t0_valid), .touch_x(t0_x), .touch_y(t0_y),
        .pen_color(t0_pen), .vram_wr_ena(r0_ena), .vram_wr_addr(r0_addr),
        .vram_wr_data(r0_data), .busy(r0_busy));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int rr_m = 0;
    logic [CW-1:0] img [NPIX];
    logic [CW-1:0] mem [NPIX];

    always @(posedge clk) begin
        if (wr_ena && (int'(wr_addr) < NPIX)) mem[wr_addr] <= wr_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_touch(input int ch, input logic v, input int x, input int y,
                             input logic [CW-1:0] col);
        touch_valid[ch]          = v;
        touch_x[ch*XW +: XW]     = XW'(x);
        touch_y[ch*YW +: YW]     = YW'(y);
        pen_color[ch*CW +: CW]   = col;
    endtask

    task automatic expect_clear(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("clear_ena", 32'(wr_ena), 32'd1);
            chk("clear_addr", 32'(wr_addr), 32'(i));
            chk("clear_data", 32'(wr_data), 32'h000F);
            chk("clear_busy", 32'(busy), (i == NPIX - 1) ? 32'd0 : 32'd1);
        end
        if (n == NPIX) for (int p = 0; p < NPIX; p++) img[p] = 16'h000F;
    endtask

    task automatic latch(input int ch);
        tick();
        chk("latch_ena", 32'(wr_ena), 32'd0);
        chk("latch_busy", 32'(busy), 32'd1);
        rr_m = (ch + 1) % N;
    endtask

    // Brush pixel i covers row offset i/3-1 and column offset i%3-1.
    task automatic expect_stroke(input int x, input int y, input logic [CW-1:0] col,
                                 input int ncyc);
        int px;
        int py;
        logic en;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            px = x + (i % 3) - 1;
            py = y + (i / 3) - 1;
            en = (px >= 0) && (px < W) && (py >= 0) && (py < H);
            chk("paint_ena", 32'(wr_ena), 32'(en));
            if (en) begin
                chk("paint_addr", 32'(wr_addr), 32'(py * W + px));
                chk("paint_data", 32'(wr_data), 32'(col));
                img[py * W + px] = col;
            end
            chk("paint_busy", 32'(busy), (i == 8) ? 32'd0 : 32'd1);
        end
    endtask

    task automatic expect_idle(input string tag);
        tick();
        chk({tag, "_ena"}, 32'(wr_ena), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch;
        int x;
        int y;
        int diff;
        logic [CW-1:0] col;
        logic [CW-1:0] col_a;
        logic [CW-1:0] col_b;

        #12;
        chk("rst_ena", 32'(wr_ena), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rstb = 1'b1;
        expect_clear(NPIX);
        expect_idle("post_clear");

        set_touch(0, 1'b1, 3, 2, 16'hF81F);
        latch(0);
        touch_valid = '0;
        expect_stroke(3, 2, 16'hF81F, 9);
        expect_idle("post_stroke");

        set_touch(0, 1'b1, 0, 0, 16'h07E0);
        latch(0);
        touch_valid = '0;
        expect_stroke(0, 0, 16'h07E0, 9);
        set_touch(0, 1'b1, 7, 5, 16'hFFE0);
        latch(0);
        touch_valid = '0;
        expect_stroke(7, 5, 16'hFFE0, 9);

        // Random single-channel strokes; the other channel may hold an off-screen touch.
        for (int k = 0; k < 6; k++) begin
            ch  = int'($urandom_range(0, N - 1));
            x   = int'($urandom_range(0, W - 1));
            y   = int'($urandom_range(0, H - 1));
            col = CW'($urandom);
            set_touch(ch, 1'b1, x, y, col);
            set_touch(1 - ch, 1'($urandom_range(0, 1)), int'($urandom_range(0, W - 1)),
                      int'($urandom_range(H, 7)), CW'($urandom));
            latch(ch);
            touch_valid = '0;
            expect_stroke(x, y, col, 9);
        end

        // Park the pointer on channel 0 so the alternation starts there.
        set_touch(1, 1'b1, int'($urandom_range(0, W - 1)), 4, 16'h1111);
        latch(1);
        touch_valid = '0;
        expect_stroke(int'(touch_x[XW +: XW]), 4, 16'h1111, 9);

        col_a = 16'hABCD;
        col_b = 16'h5A5A;
        set_touch(0, 1'b1, 1, 1, col_a);
        set_touch(1, 1'b1, 5, 3, col_b);
        for (int s = 0; s < 4; s++) begin
            ch = rr_m;
            latch(ch);
            if (ch == 0) expect_stroke(1, 1, col_a, 9);
            else         expect_stroke(5, 3, col_b, 9);
        end
        touch_valid = '0;
        expect_idle("post_alt");

        diff = 0;
        for (int p = 0; p < NPIX; p++) if (mem[p] !== img[p]) diff++;
        chk("image_diff", 32'(diff), 32'd0);

        // x cannot exceed 7 at W=8, so off-screen rejection is exercised through y.
        set_touch(1, 1'b1, 2, 6, 16'h2222);
        expect_idle("oor_y6_a");
        expect_idle("oor_y6_b");
        set_touch(1, 1'b1, 2, 7, 16'h2222);
        expect_idle("oor_y7");
        touch_valid = '0;

        set_touch(0, 1'b1, 4, 3, 16'h3333);
        latch(0);
        touch_valid = '0;
        expect_stroke(4, 3, 16'h3333, 4);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("abort_ena", 32'(wr_ena), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        expect_clear(10);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("restart_ena", 32'(wr_ena), 32'd0);
        expect_clear(NPIX);
        expect_idle("post_restart");

        set_touch(0, 1'b1, 2, 2, 16'h4444);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        touch_valid = '0;
        chk("prio_ena", 32'(wr_ena), 32'd0);
        chk("prio_busy", 32'(busy), 32'd1);
        expect_clear(NPIX);
        expect_idle("post_prio");

        set_touch(0, 1'b1, 3, 3, 16'h5555);
        latch(0);
        touch_valid = '0;
        expect_stroke(3, 3, 16'h5555, 2);
        #2;
        rstb = 1'b0;
        #1;
        chk("arst_ena", 32'(wr_ena), 32'd0);
        chk("arst_busy", 32'(busy), 32'd1);
        chk("arst_addr", 32'(wr_addr), 32'd0);
        rr_m = 0;
        @(negedge clk);
        rstb = 1'b1;
        expect_clear(NPIX);
        expect_idle("post_arst");

        t0_valid[0]  = 1'b1;
        t0_x[0 +: XW] = 3'd2;
        t0_y[0 +: YW] = 3'd2;
        t0_pen[0 +: CW] = 16'h1234;
        tick();
        t0_valid = '0;
        chk("r0_latch_ena", 32'(r0_ena), 32'd0);
        chk("r0_latch_busy", 32'(r0_busy), 32'd1);
        tick();
        chk("r0_ena", 32'(r0_ena), 32'd1);
        chk("r0_addr", 32'(r0_addr), 32'd18);
        chk("r0_data", 32'(r0_data), 32'h1234);
        chk("r0_busy", 32'(r0_busy), 32'd0);
        tick();
        chk("r0_after_ena", 32'(r0_ena), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
